// File: rtl/matrix_pkg.sv
// Shared types and the saturating add for the matrix multiplier datapath.
// The MAC selects saturating versus wrapping accumulation with MAC_SATURATE_EN.
package matrix_pkg;

  localparam int PKG_WIDTH_BIT  = 32;
  localparam int PKG_DATA_WIDTH = 16;
  localparam int PKG_ACC_WIDTH  = 40;
  localparam int WIDE           = 64;

  typedef logic        [PKG_WIDTH_BIT-1:0]    idx_t;
  typedef logic signed [PKG_DATA_WIDTH-1:0]   operand_t;
  typedef logic signed [PKG_ACC_WIDTH-1:0]    acc_t;
  typedef logic signed [2*PKG_DATA_WIDTH-1:0] product_t;

  typedef struct packed {
    product_t product;
    idx_t     i;
    idx_t     j;
    logic     first;
    logic     last;
    logic     valid;
  } mac_stage_t;

  // Both operands must already fit in 'width' bits, so the wide sum cannot overflow.
  function automatic logic signed [WIDE-1:0] sat_add(
    input logic signed [WIDE-1:0] a,
    input logic signed [WIDE-1:0] b,
    input int unsigned            width
  );
    logic signed [WIDE-1:0] sum;
    logic signed [WIDE-1:0] max_v;
    logic signed [WIDE-1:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sum > max_v) begin
      return max_v;
    end else if (sum < min_v) begin
      return min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/matrix_seq_checker.sv
// Tracks the expected row-major (i, j, k) tuple and flags any accepted tuple that deviates.
// After a deviation the expectation follows the received tuple so one glitch reports once.
module matrix_seq_checker
  import matrix_pkg::*;
#(
  parameter int AROWS     = 3,
  parameter int ACOLUMNS  = 3,
  parameter int BCOLUMNS  = 3,
  parameter int WIDTH_BIT = PKG_WIDTH_BIT
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 accept,
  input  logic [WIDTH_BIT-1:0] in_i,
  input  logic [WIDTH_BIT-1:0] in_j,
  input  logic [WIDTH_BIT-1:0] in_k,
  output logic                 err_seq
);

  localparam logic [WIDTH_BIT-1:0] I_LAST = WIDTH_BIT'(AROWS - 1);
  localparam logic [WIDTH_BIT-1:0] J_LAST = WIDTH_BIT'(BCOLUMNS - 1);
  localparam logic [WIDTH_BIT-1:0] K_LAST = WIDTH_BIT'(ACOLUMNS - 1);
  localparam logic [WIDTH_BIT-1:0] ONE    = WIDTH_BIT'(1);

  logic [WIDTH_BIT-1:0] exp_i_q, exp_i_d;
  logic [WIDTH_BIT-1:0] exp_j_q, exp_j_d;
  logic [WIDTH_BIT-1:0] exp_k_q, exp_k_d;
  logic                 err_q, err_d;
  logic                 mismatch;

  assign mismatch = (in_i != exp_i_q) || (in_j != exp_j_q) || (in_k != exp_k_q);

  always_comb begin
    exp_i_d = exp_i_q;
    exp_j_d = exp_j_q;
    exp_k_d = exp_k_q;
    err_d   = err_q;
    if (accept) begin
      if (mismatch) begin
        err_d = 1'b1;
      end
      // Successor of the received tuple; out-of-range indices wrap like the last one.
      exp_i_d = in_i;
      exp_j_d = in_j;
      exp_k_d = in_k + ONE;
      if (in_k >= K_LAST) begin
        exp_k_d = '0;
        exp_j_d = in_j + ONE;
        if (in_j >= J_LAST) begin
          exp_j_d = '0;
          exp_i_d = in_i + ONE;
          if (in_i >= I_LAST) begin
            exp_i_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      exp_i_q <= '0;
      exp_j_q <= '0;
      exp_k_q <= '0;
      err_q   <= 1'b0;
    end else begin
      exp_i_q <= exp_i_d;
      exp_j_q <= exp_j_d;
      exp_k_q <= exp_k_d;
      err_q   <= err_d;
    end
  end

  assign err_seq = err_q;

endmodule

// File: rtl/matrix_mac_accumulator.sv
// Two-stage multiply-accumulate producing C[i][j] from streamed A[i][k], B[k][j] pairs.
// Define MAC_SATURATE_EN to clamp each accumulate to the signed ACC_WIDTH range.
module matrix_mac_accumulator
  import matrix_pkg::*;
#(
  parameter int AROWS      = 3,
  parameter int ACOLUMNS   = 3,
  parameter int BCOLUMNS   = 3,
  parameter int WIDTH_BIT  = PKG_WIDTH_BIT,
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int ACC_WIDTH  = PKG_ACC_WIDTH
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_BIT-1:0]         in_i,
  input  logic [WIDTH_BIT-1:0]         in_j,
  input  logic [WIDTH_BIT-1:0]         in_k,
  input  logic signed [DATA_WIDTH-1:0] in_a,
  input  logic signed [DATA_WIDTH-1:0] in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH_BIT-1:0]         out_i,
  output logic [WIDTH_BIT-1:0]         out_j,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic                         done,
  output logic                         err_seq
);

  localparam logic [WIDTH_BIT-1:0] I_LAST = WIDTH_BIT'(AROWS - 1);
  localparam logic [WIDTH_BIT-1:0] J_LAST = WIDTH_BIT'(BCOLUMNS - 1);
  localparam logic [WIDTH_BIT-1:0] K_LAST = WIDTH_BIT'(ACOLUMNS - 1);

  logic                          stall;
  logic                          accept;
  logic signed [2*DATA_WIDTH-1:0] prod_w;
  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   acc_sum;

  mac_stage_t                    p_q, p_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]   out_data_q, out_data_d;
  logic [WIDTH_BIT-1:0]          out_i_q, out_i_d;
  logic [WIDTH_BIT-1:0]          out_j_q, out_j_d;
  logic                          out_valid_q, out_valid_d;
  logic                          done_q, done_d;

  // A pending result that is not being taken freezes the whole pipeline.
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  assign prod_w = (2*DATA_WIDTH)'(in_a) * (2*DATA_WIDTH)'(in_b);

  // Stage P: registered product and tuple bookkeeping.
  always_comb begin
    p_d = p_q;
    if (!stall) begin
      p_d.valid = accept;
      if (accept) begin
        p_d.product = prod_w;
        p_d.i       = in_i;
        p_d.j       = in_j;
        p_d.first   = (in_k == '0);
        p_d.last    = (in_k == K_LAST);
      end
    end
  end

  assign prod_s   = p_q.product;
  assign prod_ext = ACC_WIDTH'(prod_s);

`ifdef MAC_SATURATE_EN
  assign acc_sum = ACC_WIDTH'(sat_add(WIDE'(acc_q), WIDE'(prod_ext), ACC_WIDTH));
`else
  assign acc_sum = acc_q + prod_ext;
`endif

  // Stage A: accumulate and publish the finished dot product on the last k.
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_i_d     = out_i_q;
    out_j_d     = out_j_q;
    done_d      = out_valid_q && out_ready && (out_i_q == I_LAST) && (out_j_q == J_LAST);
    if (!stall) begin
      out_valid_d = 1'b0;
      if (p_q.valid) begin
        acc_d = p_q.first ? prod_ext : acc_sum;
        if (p_q.last) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_d;
          out_i_d     = p_q.i;
          out_j_d     = p_q.j;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      p_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_i_q     <= '0;
      out_j_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      p_q         <= p_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_i_q     <= out_i_d;
      out_j_q     <= out_j_d;
      done_q      <= done_d;
    end
  end

  matrix_seq_checker #(
    .AROWS     (AROWS),
    .ACOLUMNS  (ACOLUMNS),
    .BCOLUMNS  (BCOLUMNS),
    .WIDTH_BIT (WIDTH_BIT)
  ) u_seq_checker (
    .clock   (clock),
    .nreset  (nreset),
    .accept  (accept),
    .in_i    (in_i),
    .in_j    (in_j),
    .in_k    (in_k),
    .err_seq (err_seq)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_i     = out_i_q;
  assign out_j     = out_j_q;
  assign done      = done_q;

endmodule
